// File: rtl/kpn_fifo_channel.sv
// KPN channel FIFO: first-word fall-through token buffer with a preload that is
// restored on every reset, registered occupancy status and sticky error flags.
module kpn_fifo_channel #(
  parameter int BITS_NUMBER              = 16,
  parameter int FIFO_ELEMENTS            = 5,
  parameter int NUMBER_OF_PRECHARGE_DATA = 0,
  parameter logic [(2**FIFO_ELEMENTS)*BITS_NUMBER-1:0] PRECHARGE_DATA = '0,
  parameter int ALMOST_FULL_MARGIN       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [BITS_NUMBER-1:0]   entry_1,
  output logic [BITS_NUMBER-1:0]   output_1,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [FIFO_ELEMENTS:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH    = 2**FIFO_ELEMENTS;
  localparam int CW       = FIFO_ELEMENTS + 1;
  localparam int N_PRE    = NUMBER_OF_PRECHARGE_DATA;
  localparam int AF_LEVEL = DEPTH - ALMOST_FULL_MARGIN;

  localparam logic [FIFO_ELEMENTS-1:0] W_PTR_INIT = FIFO_ELEMENTS'(N_PRE % DEPTH);
  localparam logic [CW-1:0]            COUNT_INIT = CW'(N_PRE);
  localparam logic                     EMPTY_INIT = (N_PRE == 0);
  localparam logic                     FULL_INIT  = (N_PRE == DEPTH);
  localparam logic                     AF_INIT    = (N_PRE >= AF_LEVEL);

  // A preload larger than the storage cannot be represented; stop elaboration.
  if (N_PRE > DEPTH) begin : g_bad_preload
    $error("kpn_fifo_channel: NUMBER_OF_PRECHARGE_DATA exceeds FIFO depth");
  end

  logic [BITS_NUMBER-1:0]   r_mem [DEPTH];
  logic [FIFO_ELEMENTS-1:0] r_ptr;
  logic [FIFO_ELEMENTS-1:0] w_ptr;
  logic [CW-1:0]            r_count;
  logic                     r_full;
  logic                     r_empty;
  logic                     r_almost_full;
  logic                     r_overflow;
  logic                     r_underflow;

  logic                     w_pop;
  logic                     w_push;
  logic [CW-1:0]            w_count_nxt;

  // Accept decisions on pre-edge state; a full FIFO still takes a write when
  // the same cycle pops, because the popped slot is the one being written.
  always_comb begin
    w_pop       = rd && !r_empty;
    w_push      = wr && (!r_full || rd);
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage: reset reloads the preload tokens and clears the remaining slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i < N_PRE) ? PRECHARGE_DATA[i*BITS_NUMBER +: BITS_NUMBER] : '0;
      end
    end else if (w_push) begin
      r_mem[w_ptr] <= entry_1;
    end
  end

  // Pointers, occupancy, status flags and sticky errors all move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= '0;
      w_ptr         <= W_PTR_INIT;
      r_count       <= COUNT_INIT;
      r_empty       <= EMPTY_INIT;
      r_full        <= FULL_INIT;
      r_almost_full <= AF_INIT;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_pop)  r_ptr <= r_ptr + FIFO_ELEMENTS'(1);
      if (w_push) w_ptr <= w_ptr + FIFO_ELEMENTS'(1);
      r_count       <= w_count_nxt;
      r_empty       <= (w_count_nxt == '0);
      r_full        <= (w_count_nxt == CW'(DEPTH));
      r_almost_full <= (int'(w_count_nxt) >= AF_LEVEL);
      if (wr && r_full && !rd) r_overflow  <= 1'b1;
      if (rd && r_empty)       r_underflow <= 1'b1;
    end
  end

  // Head token is visible with zero latency; masked to zero when nothing is stored.
  always_comb begin
    output_1 = r_empty ? '0 : r_mem[r_ptr];
  end

  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_almost_full;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Bench for kpn_fifo_channel: directed scenarios followed by random traffic,
// every cycle compared against a queue-based token model.
module tb_kpn_fifo_channel;

  localparam int BW = 16;
  localparam int FE = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [BW-1:0] entry_1 = '0;
  logic [BW-1:0] output_1;
  logic          full, empty, almost_full, overflow, underflow;
  logic [FE:0]   count;

  int n_asrt = 0;
  int n_fail = 0;

  logic [BW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  kpn_fifo_channel #(
    .BITS_NUMBER(16),
    .FIFO_ELEMENTS(2),
    .NUMBER_OF_PRECHARGE_DATA(2),
    .PRECHARGE_DATA(32'hBBBB_AAAA),
    .ALMOST_FULL_MARGIN(1)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .entry_1(entry_1),
    .output_1(output_1), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the channel is a bounded token queue with sticky error bits.
  task automatic model_edge(input logic rs, input logic r, input logic w, input logic [BW-1:0] d);
    logic [BW-1:0] tmp;
    if (rs) begin
      q = {16'hAAAA, 16'hBBBB};
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (r && w) begin
      if (q.size() == 0) begin
        q.push_back(d);
        m_unf = 1'b1;
      end else begin
        tmp = q.pop_front();
        q.push_back(d);
      end
    end else if (r) begin
      if (q.size() == 0) m_unf = 1'b1;
      else tmp = q.pop_front();
    end else if (w) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"},  32'(full),  32'(q.size() == DEPTH));
    check({tag, "_afull"}, 32'(almost_full), 32'(q.size() >= DEPTH - 1));
    check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, "_unf"},   32'(underflow), 32'(m_unf));
    check({tag, "_out"},   32'(output_1), (q.size() == 0) ? 32'h0 : 32'(q[0]));
  endtask

  // One clock: drive, take the edge, advance the model, compare away from the edge.
  task automatic step(input string tag, input logic rs, input logic r, input logic w,
                      input logic [BW-1:0] d);
    reset = rs; rd = r; wr = w; entry_1 = d;
    @(posedge clk);
    model_edge(rs, r, w, d);
    #1;
    reset = 1'b0; rd = 1'b0; wr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // 1: preload visible after reset, single read
    step("t1_rst", 1'b1, 1'b0, 1'b0, '0);
    check("t1_out_lit", 32'(output_1), 32'hAAAA);
    check("t1_cnt_lit", 32'(count), 32'd2);
    step("t1_rd", 1'b0, 1'b1, 1'b0, '0);
    check("t1_rd_lit", 32'(output_1), 32'hBBBB);

    // 2: fill, overflow, drain in order
    step("t2_rst", 1'b1, 1'b0, 1'b0, '0);
    step("t2_w11", 1'b0, 1'b0, 1'b1, 16'h0011);
    step("t2_w22", 1'b0, 1'b0, 1'b1, 16'h0022);
    step("t2_w33", 1'b0, 1'b0, 1'b1, 16'h0033);
    step("t2_w44", 1'b0, 1'b0, 1'b1, 16'h0044);
    check("t2_ovf_lit", 32'(overflow), 32'd1);
    check("t2_full_lit", 32'(full), 32'd1);
    check("t2_h0", 32'(output_1), 32'hAAAA);
    step("t2_d0", 1'b0, 1'b1, 1'b0, '0);
    check("t2_h1", 32'(output_1), 32'hBBBB);
    step("t2_d1", 1'b0, 1'b1, 1'b0, '0);
    check("t2_h2", 32'(output_1), 32'h0011);
    step("t2_d2", 1'b0, 1'b1, 1'b0, '0);
    check("t2_h3", 32'(output_1), 32'h0022);
    step("t2_d3", 1'b0, 1'b1, 1'b0, '0);

    // 3: simultaneous read/write while full
    step("t3_rst", 1'b1, 1'b0, 1'b0, '0);
    step("t3_w1", 1'b0, 1'b0, 1'b1, 16'h0011);
    step("t3_w2", 1'b0, 1'b0, 1'b1, 16'h0022);
    step("t3_rw", 1'b0, 1'b1, 1'b1, 16'h0055);
    check("t3_cnt_lit", 32'(count), 32'd4);
    check("t3_ovf_lit", 32'(overflow), 32'd0);
    check("t3_head_lit", 32'(output_1), 32'hBBBB);
    for (int i = 0; i < 4; i++) step("t3_drain", 1'b0, 1'b1, 1'b0, '0);
    check("t3_empty_lit", 32'(empty), 32'd1);

    // 4: simultaneous read/write while empty (no bypass)
    step("t4_rw", 1'b0, 1'b1, 1'b1, 16'h0066);
    check("t4_unf_lit", 32'(underflow), 32'd1);
    check("t4_out_lit", 32'(output_1), 32'h0066);
    step("t4_rd", 1'b0, 1'b1, 1'b0, '0);
    check("t4_empty_lit", 32'(empty), 32'd1);

    // 5: pointer wrap with push/pop pairs
    step("t5_rst", 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      step("t5_push", 1'b0, 1'b0, 1'b1, 16'(i));
      step("t5_pop", 1'b0, 1'b1, 1'b0, '0);
    end

    // 6: reset in the middle of traffic
    step("t6_rst", 1'b1, 1'b0, 1'b0, '0);
    step("t6_w1", 1'b0, 1'b0, 1'b1, 16'h0001);
    step("t6_w2", 1'b0, 1'b0, 1'b1, 16'h0002);
    step("t6_w3", 1'b0, 1'b0, 1'b1, 16'h0003);
    step("t6_rd", 1'b0, 1'b1, 1'b0, '0);
    check("t6_pre_cnt", 32'(count), 32'd3);
    step("t6_mid", 1'b1, 1'b1, 1'b1, 16'h0009);
    check("t6_cnt_lit", 32'(count), 32'd2);
    check("t6_out_lit", 32'(output_1), 32'hAAAA);
    check("t6_ovf_lit", 32'(overflow), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
